tinyqv_mem_sequencer: RTL and testbench
=======================================

TINYQV_MEM_SEQUENCER -- requirements
Module: tinyqv_mem_sequencer

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_BITS, default 24: memory address width.
REQ-003 Parameter REG_ADDR_BITS, default 4: register index width.
REQ-004 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  issue a decoded load/store; sampled only in IDLE
- is_store  in  1  1 = store sequence, 0 = load sequence
- base_addr  in  ADDR_BITS  rs1+imm address of the first access
- mem_op  in  3  access size/sign code, passed through unchanged
- additional_mem_ops  in  3  extra accesses after the first (0..7)
- increment_reg  in  1  1 = step register index per access
- first_reg  in  REG_ADDR_BITS  rd (load) or rs2 (store) of the first access
- flush  in  1  abandon remaining accesses
- req_ready  in  1  memory accepts the request
- mem_done  in  1  the outstanding access has completed
- busy  out  1  sequence in progress
- req_valid  out  1  request presented to memory
- req_addr  out  ADDR_BITS  access address
- req_op  out  3  latched mem_op
- req_store  out  1  latched is_store
- req_reg  out  REG_ADDR_BITS  register for this access
- req_last  out  1  this is the final access
- reg_we  out  1  load writeback strobe for req_reg
- seq_done  out  1  one-cycle completion pulse

Function
REQ-005 The FSM SHALL have the states IDLE, REQ and WAIT.
REQ-006 IDLE with start=1: latch all inputs, set count=additional_mem_ops, and enter REQ on the next cycle.
REQ-007 In REQ, req_valid SHALL be 1; when req_ready=1 the FSM enters WAIT and req_valid drops on the next cycle.
REQ-008 In WAIT, on mem_done: if count==0 or a flush is pending, assert seq_done for one cycle and enter IDLE; otherwise decrement count, add 4 to the address, and return to REQ.
REQ-009 The total number of accesses SHALL be additional_mem_ops+1, giving 1..8.
REQ-010 The address SHALL wrap modulo 2^ADDR_BITS.
REQ-011 req_reg SHALL step by +1 per access when increment_reg=1, wrapping modulo 2^REG_ADDR_BITS (15 -> 0), and SHALL stay constant otherwise.
REQ-012 reg_we SHALL equal mem_done & WAIT & !req_store & (req_reg!=0); no writes to x0.
REQ-013 req_last SHALL be 1 whenever count==0.
REQ-014 busy SHALL be 1 in REQ and WAIT.
REQ-015 flush in REQ before acceptance: go to IDLE next cycle, issue no further requests, and pulse seq_done.
REQ-016 flush in WAIT: set a pending flag; the outstanding access completes normally (including reg_we); then go to IDLE.
REQ-017 mem_done and flush in the same WAIT cycle: that access completes and the sequence terminates.
REQ-018 start while busy SHALL be ignored.
REQ-019 Outputs SHALL be stable while req_valid=1 and req_ready=0.
REQ-020 Minimum latency from start to the first req_valid SHALL be 1 cycle.

Reset
REQ-021 Reset SHALL take priority over every other input.
REQ-022 On reset the FSM SHALL enter IDLE and busy, req_valid, reg_we, seq_done, req_last and req_store SHALL be 0.
REQ-023 On reset req_addr, req_reg, req_op and count SHALL be 0, and the flush-pending flag SHALL be cleared.
REQ-024 Reset mid-sequence SHALL abandon the sequence with no further requests.

Configuration
REQ-025 Macro TINYQV_MEMSEQ_BACK_TO_BACK_EN SHALL control back-to-back issue.
REQ-026 With the macro defined: on a non-final mem_done, the FSM goes directly to REQ with the next address/register visible in the same cycle, so req_valid rises on the following cycle.
REQ-027 Without the macro: one extra idle cycle (req_valid=0, busy=1) SHALL be inserted between mem_done and the next req_valid.
REQ-028 Access count, order and reg_we behaviour SHALL be identical in both configurations.

Structure
REQ-029 The FSM state encoding and the constant ADDR_STEP=4 SHALL live in the shared package tinyqv_pkg.
REQ-030 The module SHALL be a single flat module with no sub-modules.

Verification
REQ-031 Load: start, base_addr=0x000100, additional_mem_ops=3, first_reg=8, increment_reg=1 -> addresses 0x100/0x104/0x108/0x10C, regs 8/9/10/11, 4 reg_we, req_last only on the 4th, one seq_done.
REQ-032 Memset store: is_store=1, increment_reg=0, first_reg=5, additional_mem_ops=3 -> 4 requests all with req_reg=5, reg_we never asserted.
REQ-033 Register wrap: load with first_reg=14, additional_mem_ops=3 -> regs 14/15/0/1; reg_we is suppressed for reg 0.
REQ-034 Address wrap: base_addr=0xFFFFFC, additional_mem_ops=1 -> addresses 0xFFFFFC then 0x000000.
REQ-035 Flush in WAIT of access 2 of 8 -> access 2 completes, seq_done fires, no 3rd request; a later start is accepted.
REQ-036 Stall and reset: req_ready held 0 for 5 cycles -> outputs stable; assert rst during WAIT -> next cycle IDLE with all outputs 0; check both macro settings for 1 versus 2 cycles from mem_done to req_valid.

Source files
------------

// File: rtl/tinyqv_pkg.sv
// Shared definitions for the TinyQV multi-access load/store sequencer.
package tinyqv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } seq_state_e;

    localparam int unsigned ADDR_STEP = 4;

endpackage

// File: rtl/tinyqv_mem_sequencer.sv
// Issues 1..8 word accesses for a decoded load/store, stepping address and register index.
// Define TINYQV_MEMSEQ_BACK_TO_BACK_EN to issue the next request straight after mem_done.
module tinyqv_mem_sequencer
    import tinyqv_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [2:0]               mem_op,
    input  logic [2:0]               additional_mem_ops,
    input  logic                     increment_reg,
    input  logic [REG_ADDR_BITS-1:0] first_reg,
    input  logic                     flush,
    input  logic                     req_ready,
    input  logic                     mem_done,
    output logic                     busy,
    output logic                     req_valid,
    output logic [ADDR_BITS-1:0]     req_addr,
    output logic [2:0]               req_op,
    output logic                     req_store,
    output logic [REG_ADDR_BITS-1:0] req_reg,
    output logic                     req_last,
    output logic                     reg_we,
    output logic                     seq_done
);

    seq_state_e state;
    logic [2:0] count;
    logic       inc_reg;
    logic       flush_pend;
    logic       last_access;

    assign busy        = (state != StIdle);
    assign last_access = (count == 3'd0);
    assign req_last    = busy && last_access;
    assign reg_we      = mem_done && (state == StWait) && !req_store &&
                         (req_reg != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_op     <= 3'd0;
            req_store  <= 1'b0;
            req_reg    <= '0;
            count      <= 3'd0;
            inc_reg    <= 1'b0;
            flush_pend <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StReq;
                        req_valid  <= 1'b1;
                        req_addr   <= base_addr;
                        req_op     <= mem_op;
                        req_store  <= is_store;
                        req_reg    <= first_reg;
                        count      <= additional_mem_ops;
                        inc_reg    <= increment_reg;
                        flush_pend <= 1'b0;
                    end
                end
                StReq: begin
                    if (!req_valid) begin
                        // Spacer cycle between accesses; nothing is outstanding yet.
                        if (flush) begin
                            state    <= StIdle;
                            seq_done <= 1'b1;
                        end else begin
                            req_valid <= 1'b1;
                        end
                    end else if (req_ready) begin
                        // Once accepted the access must finish, so a same-cycle flush is deferred.
                        state      <= StWait;
                        req_valid  <= 1'b0;
                        flush_pend <= flush;
                    end else if (flush) begin
                        state     <= StIdle;
                        req_valid <= 1'b0;
                        seq_done  <= 1'b1;
                    end
                end
                StWait: begin
                    if (mem_done) begin
                        if (last_access || flush_pend || flush) begin
                            state      <= StIdle;
                            flush_pend <= 1'b0;
                            seq_done   <= 1'b1;
                        end else begin
                            state    <= StReq;
                            count    <= count - 3'd1;
                            req_addr <= req_addr + ADDR_BITS'(ADDR_STEP);
                            if (inc_reg) begin
                                req_reg <= req_reg + REG_ADDR_BITS'(1);
                            end
`ifdef TINYQV_MEMSEQ_BACK_TO_BACK_EN
                            req_valid <= 1'b1;
`else
                            req_valid <= 1'b0;
`endif
                        end
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tinyqv_mem_sequencer.sv
// Directed self-checking bench for tinyqv_mem_sequencer (both TINYQV_MEMSEQ_BACK_TO_BACK_EN settings).
module tb_tinyqv_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [23:0] base_addr;
    logic [2:0]  mem_op;
    logic [2:0]  additional_mem_ops;
    logic        increment_reg;
    logic [3:0]  first_reg;
    logic        flush;
    logic        req_ready;
    logic        mem_done;
    logic        busy;
    logic        req_valid;
    logic [23:0] req_addr;
    logic [2:0]  req_op;
    logic        req_store;
    logic [3:0]  req_reg;
    logic        req_last;
    logic        reg_we;
    logic        seq_done;

    int checks = 0;
    int errors = 0;

`ifdef TINYQV_MEMSEQ_BACK_TO_BACK_EN
    localparam int GapExp = 1;
`else
    localparam int GapExp = 2;
`endif

    // Observations gathered by run_seq, one entry per access.
    logic [23:0] got_addr [8];
    logic [3:0]  got_reg  [8];
    logic        got_last [8];
    logic        got_we   [8];
    logic [2:0]  got_op   [8];
    logic        got_st   [8];
    int          got_gap  [8];
    int          n_req;
    int          n_done;
    bit          timed_out;
    bit          gap_busy_bad;

    always #5 clk = ~clk;

    tinyqv_mem_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .is_store           (is_store),
        .base_addr          (base_addr),
        .mem_op             (mem_op),
        .additional_mem_ops (additional_mem_ops),
        .increment_reg      (increment_reg),
        .first_reg          (first_reg),
        .flush              (flush),
        .req_ready          (req_ready),
        .mem_done           (mem_done),
        .busy               (busy),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .req_op             (req_op),
        .req_store          (req_store),
        .req_reg            (req_reg),
        .req_last           (req_last),
        .reg_we             (reg_we),
        .seq_done           (seq_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [23:0] addr, input logic [2:0] op,
                         input logic [2:0] extra, input logic inc, input logic [3:0] rg);
        is_store           = st;
        base_addr          = addr;
        mem_op             = op;
        additional_mem_ops = extra;
        increment_reg      = inc;
        first_reg          = rg;
        start              = 1'b1;
        tick();
        start              = 1'b0;
    endtask

    // Memory responder: accepts each request, flushes during WAIT of access flush_at,
    // completes with mem_done one cycle later and stops at the first seq_done.
    task automatic run_seq(input int flush_at);
        int guard;
        int lat;
        n_req        = 0;
        n_done       = 0;
        timed_out    = 1'b0;
        gap_busy_bad = 1'b0;
        guard        = 0;
        for (int i = 0; i < 8; i++) got_gap[i] = 0;
        while (guard < 300) begin
            if (seq_done) begin
                n_done++;
                break;
            end
            if (req_valid && n_req < 8) begin
                got_addr[n_req] = req_addr;
                got_reg[n_req]  = req_reg;
                got_last[n_req] = req_last;
                got_op[n_req]   = req_op;
                got_st[n_req]   = req_store;
                n_req++;
                req_ready = 1'b1;
                tick();
                req_ready = 1'b0;
                if (flush_at == n_req - 1) begin
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                end
                mem_done = 1'b1;
                #1;
                got_we[n_req-1] = reg_we;
                tick();
                mem_done = 1'b0;
                lat = 1;
                while (!req_valid && !seq_done && lat < 10) begin
                    if (!busy) gap_busy_bad = 1'b1;
                    tick();
                    lat++;
                end
                got_gap[n_req-1] = lat;
                guard += lat + 2;
            end else begin
                tick();
                guard++;
            end
        end
        if (guard >= 300) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, req_valid, reg_we, seq_done, req_last, req_store} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {busy, req_valid, reg_we, seq_done, req_last, req_store});
        end
        checks++;
        if (req_addr !== 24'h0 || req_reg !== 4'h0 || req_op !== 3'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h reg %h op %h required all 0",
                     req_addr, req_reg, req_op);
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
    endtask

    task automatic test_load();
        issue(1'b0, 24'h000100, 3'b010, 3'd3, 1'b1, 4'd8);
        checks++;
        if (req_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_latency: valid %b busy %b required 1 1", req_valid, busy);
        end
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 4 || n_done != 1) begin
            errors++;
            $display("FAIL load_count: reqs %0d done %0d timeout %0d required 4 1 0",
                     n_req, n_done, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_addr[i] !== 24'h100 + 24'(4 * i) || got_reg[i] !== 4'(8 + i) ||
                got_last[i] !== (i == 3) || got_we[i] !== 1'b1 ||
                got_op[i] !== 3'b010 || got_st[i] !== 1'b0) begin
                errors++;
                $display("FAIL load_access%0d: addr %h reg %0d last %b we %b op %b st %b",
                         i, got_addr[i], got_reg[i], got_last[i], got_we[i], got_op[i],
                         got_st[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_gap[i] != GapExp) begin
                errors++;
                $display("FAIL load_gap%0d: got %0d required %0d", i, got_gap[i], GapExp);
            end
        end
        checks++;
        if (gap_busy_bad) begin
            errors++;
            $display("FAIL load_gap_busy: busy dropped between accesses, required 1");
        end
        tick();
        checks++;
        if (seq_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done_pulse: seq_done %b busy %b required 0 0", seq_done, busy);
        end
    endtask

    task automatic test_memset();
        issue(1'b1, 24'h000400, 3'b010, 3'd3, 1'b0, 4'd5);
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 4 || n_done != 1) begin
            errors++;
            $display("FAIL memset_count: reqs %0d done %0d required 4 1", n_req, n_done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_reg[i] !== 4'd5 || got_we[i] !== 1'b0 || got_st[i] !== 1'b1 ||
                got_addr[i] !== 24'h400 + 24'(4 * i)) begin
                errors++;
                $display("FAIL memset_access%0d: reg %0d we %b st %b addr %h", i,
                         got_reg[i], got_we[i], got_st[i], got_addr[i]);
            end
        end
        tick();
    endtask

    task automatic test_reg_wrap();
        logic [3:0] exp_reg [4];
        logic       exp_we  [4];
        exp_reg = '{4'd14, 4'd15, 4'd0, 4'd1};
        exp_we  = '{1'b1, 1'b1, 1'b0, 1'b1};
        issue(1'b0, 24'h000200, 3'b010, 3'd3, 1'b1, 4'd14);
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 4) begin
            errors++;
            $display("FAIL regwrap_count: reqs %0d required 4", n_req);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_reg[i] !== exp_reg[i] || got_we[i] !== exp_we[i]) begin
                errors++;
                $display("FAIL regwrap_access%0d: reg %0d we %b required %0d %b", i,
                         got_reg[i], got_we[i], exp_reg[i], exp_we[i]);
            end
        end
        tick();
    endtask

    task automatic test_addr_wrap();
        issue(1'b0, 24'hFFFFFC, 3'b010, 3'd1, 1'b1, 4'd2);
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 2 || got_addr[0] !== 24'hFFFFFC || got_addr[1] !== 24'h000000)
        begin
            errors++;
            $display("FAIL addrwrap: reqs %0d addr %h %h required 2 fffffc 000000",
                     n_req, got_addr[0], got_addr[1]);
        end
        tick();
    endtask

    task automatic test_flush_wait();
        issue(1'b0, 24'h000800, 3'b010, 3'd7, 1'b1, 4'd3);
        run_seq(1);
        checks++;
        if (timed_out || n_req != 2 || n_done != 1) begin
            errors++;
            $display("FAIL flushwait_count: reqs %0d done %0d required 2 1", n_req, n_done);
        end
        checks++;
        if (got_we[1] !== 1'b1 || got_reg[1] !== 4'd4) begin
            errors++;
            $display("FAIL flushwait_access: we %b reg %0d required 1 4", got_we[1], got_reg[1]);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flushwait_idle: valid %b busy %b required 0 0", req_valid, busy);
        end
        issue(1'b0, 24'h000900, 3'b010, 3'd0, 1'b1, 4'd6);
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 1 || got_addr[0] !== 24'h000900) begin
            errors++;
            $display("FAIL flushwait_restart: reqs %0d addr %h required 1 000900",
                     n_req, got_addr[0]);
        end
        tick();
    endtask

    task automatic test_flush_req();
        issue(1'b0, 24'h000A00, 3'b010, 3'd3, 1'b1, 4'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (seq_done !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushreq: done %b busy %b valid %b required 1 0 0",
                     seq_done, busy, req_valid);
        end
        tick();
        tick();
        checks++;
        if (req_valid !== 1'b0 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL flushreq_after: valid %b done %b required 0 0", req_valid, seq_done);
        end
    endtask

    task automatic test_start_ignored();
        issue(1'b0, 24'h000C00, 3'b001, 3'd1, 1'b1, 4'd7);
        issue(1'b1, 24'h00DD00, 3'b100, 3'd5, 1'b0, 4'd2);
        run_seq(-1);
        checks++;
        if (timed_out || n_req != 2 || got_addr[1] !== 24'h000C04 || got_reg[1] !== 4'd8 ||
            got_st[1] !== 1'b0 || got_op[1] !== 3'b001) begin
            errors++;
            $display("FAIL start_busy: reqs %0d addr %h reg %0d st %b op %b required 2 c04 8 0 001",
                     n_req, got_addr[1], got_reg[1], got_st[1], got_op[1]);
        end
        tick();
    endtask

    task automatic test_stall_reset();
        logic [23:0] a0;
        logic [3:0]  r0;
        bit          moved;
        issue(1'b0, 24'h000500, 3'b010, 3'd2, 1'b1, 4'd9);
        a0    = req_addr;
        r0    = req_reg;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (req_valid !== 1'b1 || req_addr !== a0 || req_reg !== r0 || req_last !== 1'b0)
                moved = 1'b1;
        end
        checks++;
        if (moved || a0 !== 24'h000500 || r0 !== 4'd9) begin
            errors++;
            $display("FAIL stall_stable: addr %h reg %0d valid %b required 000500 9 1",
                     req_addr, req_reg, req_valid);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, req_valid, reg_we, seq_done, req_last, req_store} !== 6'b0 ||
            req_addr !== 24'h0 || req_reg !== 4'h0) begin
            errors++;
            $display("FAIL reset_wait: ctrl %b addr %h reg %h required 0",
                     {busy, req_valid, reg_we, seq_done, req_last, req_store}, req_addr, req_reg);
        end
        moved = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_valid !== 1'b0 || busy !== 1'b0) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL reset_abandon: valid %b busy %b required 0 0", req_valid, busy);
        end
    endtask

    initial begin
        rst                = 1'b0;
        start              = 1'b0;
        is_store           = 1'b0;
        base_addr          = '0;
        mem_op             = '0;
        additional_mem_ops = '0;
        increment_reg      = 1'b0;
        first_reg          = '0;
        flush              = 1'b0;
        req_ready          = 1'b0;
        mem_done           = 1'b0;
        #2;
        test_reset();
        test_load();
        test_memset();
        test_reg_wrap();
        test_addr_wrap();
        test_flush_wait();
        test_flush_req();
        test_start_ignored();
        test_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
